cell_share_arbiter: RTL
=======================

# cell_share_arbiter

Round-robin arbiter that time-shares one instance of the primitive logic-cell datapath between up to eight requesters in a Wokwi-derived design. Each requester raises a request, receives a registered one-hot grant, and releases the resource with a done strobe. A hold-time limit stops any single requester from monopolising the cell. The block sits between the requester logic and the shared cell's input mux; its `gnt_id` output drives that mux's select.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 16: maximum number of consecutive cycles a grant may stay asserted; legal range 2..255.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N_REQ  request vector; bit i belongs to requester i.
- `done`  in  N_REQ  release strobe; bit i is honoured only while requester i holds the grant.
- `gnt`  out  N_REQ  one-hot grant, registered; all zero when idle.
- `gnt_id`  out  max(1,$clog2(N_REQ))  binary index of the granted requester; holds the last value when idle.
- `busy`  out  1  high while any grant is asserted (OR of `gnt`).
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Two states, IDLE and GRANT, plus a round-robin pointer `ptr` (0..N_REQ-1) and a hold counter `hold_cnt` (8 bits).
- IDLE:
  - If `req` is nonzero, select the first set bit searching upward from `ptr`, wrapping from N_REQ-1 to 0.
  - Load `gnt` (one-hot) and `gnt_id`, clear `hold_cnt`, and enter GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT, holder i. Evaluate the following in order each cycle:
  - `done[i]`=1 or `req[i]`=0: release.
  - Otherwise, if `hold_cnt`==MAX_HOLD-1: release and pulse `timeout`.
  - Otherwise: increment `hold_cnt` and keep the grant.
- On release:
  - `gnt` becomes 0.
  - `ptr` becomes (i+1) mod N_REQ.
  - State returns to IDLE.
- Requests from other requesters arriving during GRANT are not evaluated until IDLE.
- `done` bits of non-holders are ignored.
- `req` is level-sensitive and not latched. A request that drops before it is sampled in IDLE is lost.
- Reset values:
  - `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0.
  - `ptr`=0, `hold_cnt`=0, state IDLE.

## Timing
- Grant latency: `req` sampled high at edge k in IDLE gives `gnt` high after edge k, i.e. visible during cycle k+1.
- Release latency: `done[i]` sampled at edge m drops `gnt` after edge m.
- Turnaround: at least one IDLE cycle always separates two grants, so `gnt` is never back-to-back between different requesters.
- Hold limit: an uninterrupted grant is high for exactly MAX_HOLD cycles. `timeout` is high in the first cycle `gnt` is low.
- If `done[i]` and the hold limit coincide, `done` wins and `timeout` stays 0.
- `busy` and `gnt` change on the same edge; there are no combinational paths from inputs to outputs.
- If `rst` is high at an edge mid-grant, all outputs hold their reset values from that edge on. `ptr` returns to 0, so after reset requester 0 has first priority.
- Exactly one or zero bits of `gnt` are set in every cycle.

## Test plan
- Reset, then single request: `req`=0b0100 from cycle 2 → `gnt`=0b0100, `gnt_id`=2, `busy`=1 from cycle 3. Then `done`=0b0100 at cycle 6 → `gnt`=0 from cycle 7 and `ptr`=3.
- Round-robin fairness: `req`=0b1111 held constant, each holder pulses `done` one cycle after its grant → grant order 0,1,2,3,0, with exactly one idle cycle between grants.
- Hold limit with MAX_HOLD=4: `req`=0b0001 held, `done`=0 → `gnt`=0b0001 for exactly 4 cycles, then `timeout`=1 for one cycle and `gnt`=0. Regrant to requester 0 follows after IDLE because it is the only requester.
- Coincident done and limit: `done[0]` asserted in the 4th grant cycle with MAX_HOLD=4 → `gnt` drops and `timeout` stays 0.
- Request withdrawal and foreign done: holder 1 active; `done`=0b0010 is expected to release, but first drive `done`=0b0100 → ignored and grant kept. Then drive `req[1]`=0 → `gnt` drops the next cycle.
- Reset mid-grant: `gnt`=0b1000 active, `rst`=1 for one cycle → `gnt`=0 and `gnt_id`=0 after that edge. With `req`=0b1001, the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/cell_share_arbiter.sv
// cell_share_arbiter: round-robin arbiter time-sharing one logic cell among N_REQ requesters with a hold limit
module cell_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  localparam int IW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n, gnt_id_n, sel_id, nxt_ptr;
  logic [N_REQ-1:0] gnt_n;
  logic [7:0]       hold_cnt, hold_n;
  logic             timeout_n, found, rel, lim;
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel_id = IW'(idx);
      end
    end
  end
  // done wins over the hold limit, so timeout only fires when the holder did not release
  assign rel     = done[gnt_id] || !req[gnt_id];
  assign lim     = hold_cnt == 8'(MAX_HOLD - 1);
  assign nxt_ptr = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign busy    = |gnt;
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    if (state == IDLE && found) begin
      state_n  = GRANT;
      gnt_n    = N_REQ'(1) << sel_id;
      gnt_id_n = sel_id;
      hold_n   = '0;
    end else if (state == GRANT) begin
      if (rel || lim) begin
        state_n   = IDLE;
        gnt_n     = '0;
        ptr_n     = nxt_ptr;
        timeout_n = !rel;
      end else begin
        hold_n = hold_cnt + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      timeout  <= timeout_n;
    end
  end
endmodule
